// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, with loads done as a single read
// and unaligned stores done as a two-word read-modify-write.
module mem_access_unit #(
   parameter int BIT_NUMBER  = 8,
   parameter int MEM_VOL     = 1024,
   parameter int ADDR_OFFSET = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic                    req_write,
   input  logic [31:0]             req_addr,
   input  logic [4*BIT_NUMBER-1:0] req_wdata,
   output logic                    req_ready,
   output logic                    resp_valid,
   output logic [4*BIT_NUMBER-1:0] resp_rdata,
   output logic                    resp_err,
   output logic [31:0]             mem_addr,
   output logic [4*BIT_NUMBER-1:0] mem_value,
   output logic                    mem_w_en,
   output logic                    mem_r_en,
   input  logic [4*BIT_NUMBER-1:0] mem_rdata
);
   localparam int W = 4 * BIT_NUMBER;
   localparam logic [32:0] LIMIT = 33'(4 * MEM_VOL);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ST    = 3'd2,
      S_RD_LO = 3'd3,
      S_RD_HI = 3'd4,
      S_WR_LO = 3'd5,
      S_WR_HI = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   state_t         state_q;
   logic [31:0]    off_q;
   logic [W-1:0]   wdata_q;
   logic [W-1:0]   lo_q;
   logic [W-1:0]   hi_q;
   logic           resp_valid_q;
   logic [W-1:0]   resp_rdata_q;
   logic           resp_err_q;

   logic [31:0]    off_s;
   logic [31:0]    a0_s;
   logic           unal_s;
   logic           in_range_s;
   logic [31:0]    cur_a0_s;
   logic [2*W-1:0] win_s;

   // Decode the incoming address; 33-bit sums keep wrapped offsets from passing the bound.
   always_comb begin
      off_s  = req_addr - 32'(ADDR_OFFSET);
      a0_s   = {off_s[31:2], 2'b00};
      unal_s = (off_s[1:0] != 2'b00);
      if (req_write && unal_s) begin
         in_range_s = (({1'b0, a0_s} + 33'd7) < LIMIT);
      end else begin
         in_range_s = (({1'b0, off_s} + 33'd3) < LIMIT);
      end
   end

   // Merge store data into the two-word window read back during RD_LO/RD_HI.
   always_comb begin
      cur_a0_s = {off_q[31:2], 2'b00};
      win_s    = {hi_q, lo_q};
      win_s[int'(off_q[1:0]) * BIT_NUMBER +: W] = wdata_q;
   end

   // Control FSM with captured request fields and registered response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         off_q        <= 32'd0;
         wdata_q      <= '0;
         lo_q         <= '0;
         hi_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  off_q   <= off_s;
                  wdata_q <= req_wdata;
                  if (!in_range_s) begin
                     state_q <= S_ERR;
                  end else if (!req_write) begin
                     state_q <= S_LOAD;
                  end else if (unal_s) begin
                     state_q <= S_RD_LO;
                  end else begin
                     state_q <= S_ST;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_LOAD: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= mem_rdata;
               resp_err_q   <= 1'b0;
               state_q      <= S_IDLE;
            end
            S_ST, S_WR_HI: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= '0;
               resp_err_q   <= 1'b0;
               state_q      <= S_IDLE;
            end
            S_ERR: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= '0;
               resp_err_q   <= 1'b1;
               state_q      <= S_IDLE;
            end
            S_RD_LO: begin
               lo_q    <= mem_rdata;
               state_q <= S_RD_HI;
            end
            S_RD_HI: begin
               hi_q    <= mem_rdata;
               state_q <= S_WR_LO;
            end
            S_WR_LO: begin
               state_q <= S_WR_HI;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Memory port drive, decoded from the current state.
   always_comb begin
      mem_addr  = 32'd0;
      mem_value = '0;
      mem_w_en  = 1'b0;
      mem_r_en  = 1'b0;
      case (state_q)
         S_LOAD: begin
            mem_r_en = 1'b1;
            mem_addr = off_q;
         end
         S_ST: begin
            mem_w_en  = 1'b1;
            mem_addr  = cur_a0_s;
            mem_value = wdata_q;
         end
         S_RD_LO: begin
            mem_r_en = 1'b1;
            mem_addr = cur_a0_s;
         end
         S_RD_HI: begin
            mem_r_en = 1'b1;
            mem_addr = cur_a0_s + 32'd4;
         end
         S_WR_LO: begin
            mem_w_en  = 1'b1;
            mem_addr  = cur_a0_s;
            mem_value = win_s[W-1:0];
         end
         S_WR_HI: begin
            mem_w_en  = 1'b1;
            mem_addr  = cur_a0_s + 32'd4;
            mem_value = win_s[2*W-1:W];
         end
         default: begin
            mem_addr = 32'd0;
         end
      endcase
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array memory model, reference byte image,
// and a response monitor popping expected results.
module tb_mem_access_unit;
   localparam int MEM_VOL = 1024;
   localparam int NBYTES  = 4 * MEM_VOL;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        req_ready, resp_valid, resp_err, mem_w_en, mem_r_en;
   logic [31:0] resp_rdata, mem_addr, mem_value, mem_rdata;

   typedef struct {logic [31:0] rdata; logic err;} exp_t;
   exp_t exp_q[$];

   logic [7:0] mem [0:NBYTES-1];
   logic [7:0] ref_mem [0:NBYTES-1];
   int checks = 0;
   int errors = 0;
   logic [31:0] last_w_addr;

   mem_access_unit #(.BIT_NUMBER(8), .MEM_VOL(MEM_VOL), .ADDR_OFFSET(1024)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_value(mem_value), .mem_w_en(mem_w_en),
      .mem_r_en(mem_r_en), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always_comb begin
      mem_rdata = 32'd0;
      if (mem_addr < 32'(NBYTES - 3)) begin
         mem_rdata = {mem[mem_addr+3], mem[mem_addr+2], mem[mem_addr+1], mem[mem_addr]};
      end
   end

   always @(posedge clk) begin
      if (mem_w_en && mem_addr < 32'(NBYTES - 3)) begin
         for (int b = 0; b < 4; b++) mem[{mem_addr[31:2], 2'b00} + b] <= mem_value[8*b +: 8];
      end
   end

   function automatic logic [31:0] mem_word(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   function automatic logic [31:0] ref_word(input int a);
      return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
   endfunction

   task automatic preset_word(input int a, input logic [31:0] v);
      for (int b = 0; b < 4; b++) begin
         mem[a+b]     = v[8*b +: 8];
         ref_mem[a+b] = v[8*b +: 8];
      end
   endtask

   // Response monitor: pops the scoreboard on every resp_valid.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_r_en && mem_w_en) begin
            errors++;
            $display("FAIL exclusivity: r_en=%b w_en=%b both high", mem_r_en, mem_w_en);
         end
         if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp: got rdata=%h err=%b, none expected", resp_rdata, resp_err);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                  errors++;
                  $display("FAIL resp: got rdata=%h err=%b, expected rdata=%h err=%b",
                           resp_rdata, resp_err, e.rdata, e.err);
               end
            end
         end
      end
   end

   // Wait for ready, present the request for one accept edge, push the expectation.
   task automatic accept(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic exp_err);
      int n;
      exp_t e;
      int off;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         errors++;
         $display("FAIL ready_timeout: req_ready=%b expected 1", req_ready);
      end
      req_valid = 1'b1;
      req_write = w;
      req_addr  = addr;
      req_wdata = data;
      @(posedge clk);
      off = int'(addr - 32'd1024);
      e.err   = exp_err;
      e.rdata = 32'd0;
      if (!exp_err && !w) e.rdata = ref_word(off);
      if (!exp_err && w) begin
         for (int b = 0; b < 4; b++) ref_mem[off+b] = data[8*b +: 8];
      end
      exp_q.push_back(e);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   task automatic do_req(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic exp_err);
      int n, wc, rc, exp_lat, exp_wc, exp_rc;
      logic unal;
      unal = (addr[1:0] != 2'b00);
      exp_lat = (w && unal && !exp_err) ? 4 : 1;
      exp_wc  = exp_err ? 0 : (w ? (unal ? 2 : 1) : 0);
      exp_rc  = exp_err ? 0 : (w ? (unal ? 2 : 0) : 1);
      accept(w, addr, data, exp_err);
      n = 0; wc = 0; rc = 0;
      while (!resp_valid && n < 20) begin
         if (mem_w_en) begin
            if (wc == 0) last_w_addr = mem_addr;
            wc++;
         end
         if (mem_r_en) rc++;
         @(posedge clk);
         #1;
         n++;
      end
      checks += 3;
      if (n != exp_lat) begin
         errors++;
         $display("FAIL latency @%h: got %0d edges, expected %0d", addr, n, exp_lat);
      end
      if (wc != exp_wc) begin
         errors++;
         $display("FAIL w_en_cycles @%h: got %0d, expected %0d", addr, wc, exp_wc);
      end
      if (rc != exp_rc) begin
         errors++;
         $display("FAIL r_en_cycles @%h: got %0d, expected %0d", addr, rc, exp_rc);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
          mem_addr !== 32'd0 || mem_value !== 32'd0 || mem_w_en !== 1'b0 || mem_r_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: ready=%b rv=%b rd=%h err=%b ma=%h mv=%h we=%b re=%b, expected 1 0 0 0 0 0 0 0",
                  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_value, mem_w_en, mem_r_en);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_aligned;
      preset_word(0, 32'hDEADBEEF);
      do_req(1'b1, 32'd1024, 32'h00002000, 1'b0);
      checks += 2;
      if (last_w_addr !== 32'd0) begin
         errors++;
         $display("FAIL st_addr: got %h, expected 00000000", last_w_addr);
      end
      if (mem_word(0) !== 32'h00002000) begin
         errors++;
         $display("FAIL st_word0: got %h, expected 00002000", mem_word(0));
      end
      do_req(1'b0, 32'd1024, 32'd0, 1'b0);
   endtask

   task automatic test_unaligned;
      preset_word(0, 32'h11111111);
      preset_word(4, 32'h22222222);
      do_req(1'b1, 32'd1026, 32'hAABBCCDD, 1'b0);
      checks += 2;
      if (mem_word(0) !== 32'hCCDD1111) begin
         errors++;
         $display("FAIL unal_word0: got %h, expected ccdd1111", mem_word(0));
      end
      if (mem_word(4) !== 32'h2222AABB) begin
         errors++;
         $display("FAIL unal_word1: got %h, expected 2222aabb", mem_word(4));
      end
      do_req(1'b0, 32'd1026, 32'd0, 1'b0);
      do_req(1'b0, 32'd1027, 32'd0, 1'b0);
   endtask

   task automatic test_range;
      preset_word(NBYTES - 4, 32'h5A5A0F0F);
      do_req(1'b0, 32'd1000, 32'd0, 1'b1);
      do_req(1'b1, 32'(1024 + NBYTES - 2), 32'hCAFEBABE, 1'b1);
      do_req(1'b0, 32'(1024 + NBYTES - 3), 32'd0, 1'b1);
      do_req(1'b0, 32'(1024 + NBYTES - 4), 32'd0, 1'b0);
      do_req(1'b1, 32'(1024 + NBYTES - 4), 32'h01020304, 1'b0);
      do_req(1'b1, 32'(1024 + NBYTES - 8), 32'h0BADF00D, 1'b0);
      checks++;
      if (mem_word(NBYTES - 4) !== 32'h01020304) begin
         errors++;
         $display("FAIL top_word: got %h, expected 01020304", mem_word(NBYTES - 4));
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1024;
      @(posedge clk);
      e.err = 1'b0; e.rdata = ref_word(0);
      exp_q.push_back(e);
      #1 req_addr = 32'd1028;
      e.rdata = ref_word(4);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: rv=%b ready=%b, expected 1 1", resp_valid, req_ready);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: ready=%b, expected 0", req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: rv=%b, expected 1", resp_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_pending: %0d left, expected 0", exp_q.size());
      end
   endtask

   task automatic test_busy_ignore;
      int n;
      preset_word(8, 32'h99999999);
      preset_word(12, 32'h88888888);
      accept(1'b1, 32'd1035, 32'h13572468, 1'b0);
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd1024; req_wdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      checks += 4;
      if (n != 2) begin
         errors++;
         $display("FAIL busy_latency: got %0d more edges, expected 2", n);
      end
      if (mem_word(8) !== ref_word(8) || mem_word(8) !== 32'h68999999) begin
         errors++;
         $display("FAIL busy_word8: got %h, expected 68999999", mem_word(8));
      end
      if (mem_word(12) !== 32'h88135724) begin
         errors++;
         $display("FAIL busy_word12: got %h, expected 88135724", mem_word(12));
      end
      if (mem_word(0) !== ref_word(0)) begin
         errors++;
         $display("FAIL busy_word0: got %h, expected %h", mem_word(0), ref_word(0));
      end
   endtask

   task automatic test_reset_mid_store;
      preset_word(16, 32'h33333333);
      preset_word(20, 32'h44444444);
      accept(1'b1, 32'd1042, 32'h55667788, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mem_w_en !== 1'b1 || mem_addr !== 32'd20) begin
         errors++;
         $display("FAIL wr_hi_state: we=%b ma=%h, expected 1 00000014", mem_w_en, mem_addr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
          mem_addr !== 32'd0 || mem_value !== 32'd0 || mem_w_en !== 1'b0 || mem_r_en !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: ready=%b rv=%b rd=%h err=%b ma=%h mv=%h we=%b re=%b",
                  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_value, mem_w_en, mem_r_en);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      preset_word(20, 32'h44444444);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_resp: rv=%b, expected 0", resp_valid);
         end
      end
      checks += 2;
      if (mem_word(16) !== 32'h77883333) begin
         errors++;
         $display("FAIL abort_lo: got %h, expected 77883333", mem_word(16));
      end
      if (mem_word(20) !== 32'h44444444) begin
         errors++;
         $display("FAIL abort_hi: got %h, expected 44444444", mem_word(20));
      end
   endtask

   initial begin
      for (int i = 0; i < NBYTES; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      last_w_addr = 32'hFFFFFFFF;
      test_reset();
      test_aligned();
      test_unaligned();
      test_range();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid_store();
      do_req(1'b0, 32'd1040, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_final: %0d responses missing, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
